// File: rtl/sram_ctrl.sv
// 32-bit bus to 16-bit asynchronous SRAM controller; each word is two sequenced halfword cycles.
// Optional address error reporting is enabled by defining SRAM_CTRL_ERR_EN.
module sram_ctrl #(
  parameter int unsigned SRAM_AW    = 18,
  parameter int unsigned ACC_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bus_req,
  input  logic               bus_write,
  input  logic [31:0]        bus_addr,
  input  logic [31:0]        bus_wdata,
  input  logic [3:0]         bus_byte_en,
  output logic               bus_ack,
  output logic [31:0]        bus_rdata,
  output logic               bus_err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_lb_n,
  output logic               sram_ub_n
);

  localparam int unsigned WaW     = SRAM_AW - 1;
  localparam logic [3:0]  AccLast = 4'(ACC_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StAccess, StHold, StDone} state_e;

  state_e           state_q, state_d;
  logic             half_q, half_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             write_q, err_q;
  logic [WaW-1:0]   waddr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic [31:0]      rdata_d;

  logic             accept, req_err;
  logic             cur_write, cur_err;
  logic [WaW-1:0]   cur_waddr;
  logic [31:0]      cur_wdata;
  logic [3:0]       cur_be;
  logic [1:0]       sel_be;
  logic             active_d;

  logic               ce_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d, dq_oe_d, ack_d, err_d;
  logic [SRAM_AW-1:0] addr_d;
  logic [15:0]        dq_out_d;

`ifdef SRAM_CTRL_ERR_EN
  assign req_err = (bus_addr[31:SRAM_AW+1] != '0) || (bus_addr[1:0] != 2'b00);
`else
  // Out-of-range and misaligned addresses simply alias into the SRAM.
  logic unused_addr;
  assign unused_addr = ^{bus_addr[31:SRAM_AW+1], bus_addr[1:0]};
  assign req_err     = 1'b0;
`endif

  assign accept = (state_q == StIdle) && bus_req;

  // Request fields as seen by the next cycle; needed because outputs are registered.
  assign cur_write = accept ? bus_write              : write_q;
  assign cur_waddr = accept ? bus_addr[SRAM_AW:2]    : waddr_q;
  assign cur_wdata = accept ? bus_wdata              : wdata_q;
  assign cur_be    = accept ? bus_byte_en            : be_q;
  assign cur_err   = accept ? req_err                : err_q;

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    rdata_d = bus_rdata;
    unique case (state_q)
      StIdle: begin
        if (bus_req) begin
          half_d = 1'b0;
          if (req_err) begin
            state_d = StDone;
            rdata_d = '0;
          end else if (!bus_write || (bus_byte_en[1:0] != 2'b00)) begin
            state_d = StSetup;
          end else if (bus_byte_en[3:2] != 2'b00) begin
            state_d = StSetup;
            half_d  = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StSetup: begin
        state_d = StAccess;
        cnt_d   = AccLast;
      end
      StAccess: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (write_q) begin
          state_d = StHold;
        end else begin
          if (half_q) rdata_d[31:16] = sram_dq_in;
          else        rdata_d[15:0]  = sram_dq_in;
          if (!half_q) begin
            state_d = StSetup;
            half_d  = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StHold: begin
        if (!half_q && (be_q[3:2] != 2'b00)) begin
          state_d = StSetup;
          half_d  = 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pin values for the next cycle, decoded from the next state so every pin is a flop.
  always_comb begin
    active_d = (state_d == StSetup) || (state_d == StAccess) || (state_d == StHold);
    sel_be   = half_d ? cur_be[3:2] : cur_be[1:0];
    ce_n_d   = !active_d;
    oe_n_d   = !((state_d == StAccess) && !cur_write);
    we_n_d   = !((state_d == StAccess) && cur_write);
    dq_oe_d  = active_d && cur_write;
    lb_n_d   = active_d ? (cur_write ? !sel_be[0] : 1'b0) : 1'b1;
    ub_n_d   = active_d ? (cur_write ? !sel_be[1] : 1'b0) : 1'b1;
    addr_d   = active_d ? {cur_waddr, half_d} : sram_addr;
    dq_out_d = (active_d && cur_write) ? (half_d ? cur_wdata[31:16] : cur_wdata[15:0])
                                       : sram_dq_out;
    ack_d    = (state_d == StDone);
    err_d    = ack_d && cur_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      half_q      <= 1'b0;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      bus_rdata   <= '0;
      bus_ack     <= 1'b0;
      bus_err     <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      cnt_q       <= cnt_d;
      if (accept) begin
        write_q <= bus_write;
        err_q   <= req_err;
        waddr_q <= bus_addr[SRAM_AW:2];
        wdata_q <= bus_wdata;
        be_q    <= bus_byte_en;
      end
      bus_rdata   <= rdata_d;
      bus_ack     <= ack_d;
      bus_err     <= err_d;
      sram_addr   <= addr_d;
      sram_dq_out <= dq_out_d;
      sram_dq_oe  <= dq_oe_d;
      sram_ce_n   <= ce_n_d;
      sram_oe_n   <= oe_n_d;
      sram_we_n   <= we_n_d;
      sram_lb_n   <= lb_n_d;
      sram_ub_n   <= ub_n_d;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomised bench for sram_ctrl: SRAM device model plus an independent word-level reference.
// Error-reporting expectations follow SRAM_CTRL_ERR_EN when it is defined.
module tb_sram_ctrl;

  localparam int unsigned Aw  = 18;
  localparam int unsigned Acc = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          bus_req = 1'b0, bus_write = 1'b0;
  logic [31:0]   bus_addr = '0, bus_wdata = '0;
  logic [3:0]    bus_byte_en = '0;
  logic          bus_ack, bus_err;
  logic [31:0]   bus_rdata;
  logic [Aw-1:0] sram_addr;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  sram_ctrl #(.SRAM_AW(Aw), .ACC_CYCLES(Acc)) dut (
    .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_byte_en(bus_byte_en), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_err(bus_err), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM device: reads while CE/OE low, commits lanes on the WE rising edge.
  logic [15:0] mem     [0:(1<<Aw)-1];
  logic [15:0] ref_mem [0:(1<<Aw)-1];
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hA5C3;

  always @(posedge sram_we_n) begin
    if (!sram_ce_n && sram_dq_oe) begin
      if (!sram_lb_n) mem[sram_addr][7:0]  = sram_dq_out[7:0];
      if (!sram_ub_n) mem[sram_addr][15:8] = sram_dq_out[15:8];
    end
  end

  int overlap_cnt = 0;
  always @(negedge clk) if (sram_dq_oe && !sram_oe_n) overlap_cnt++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Results of the last transaction.
  int          t_lat, t_ce, t_we, t_oe, t_dqoe;
  logic        t_ack, t_err;
  logic [31:0] t_rdata;

  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
    @(negedge clk);
    bus_req = 1'b1; bus_write = wr; bus_addr = addr; bus_wdata = wdata; bus_byte_en = be;
    @(posedge clk);
    t_lat = 0; t_ce = 0; t_we = 0; t_oe = 0; t_dqoe = 0; t_ack = 1'b0; t_err = 1'b0;
    t_rdata = '0;
    for (int i = 0; i < 64 && !t_ack; i++) begin
      @(negedge clk);
      t_lat++;
      if (!sram_ce_n) t_ce++;
      if (!sram_we_n) t_we++;
      if (!sram_oe_n) t_oe++;
      if (sram_dq_oe) t_dqoe++;
      if (bus_ack) begin
        t_ack = 1'b1; t_err = bus_err; t_rdata = bus_rdata;
      end
    end
    bus_req = 1'b0;
    check_eq("ack_seen", t_ack, 1'b1);
  endtask

  function automatic logic exp_err_of(input logic [31:0] addr);
`ifdef SRAM_CTRL_ERR_EN
    return (addr[31:Aw+1] != '0) || (addr[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int hw_of(input logic [31:0] addr, input int h);
    return int'(addr[Aw:2]) * 2 + h;
  endfunction

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
    int halves = 0;
    logic e = exp_err_of(addr);
    run_txn(1'b1, addr, wdata, be);
    if (!e) begin
      for (int h = 0; h < 2; h++) begin
        if (be[2*h+:2] != 2'b00) halves++;
        if (be[2*h])   ref_mem[hw_of(addr, h)][7:0]  = wdata[16*h+:8];
        if (be[2*h+1]) ref_mem[hw_of(addr, h)][15:8] = wdata[16*h+8+:8];
      end
    end
    check_eq({tag, "_lat"}, t_lat, (halves == 0) ? 1 : halves * (2 + Acc) + 1);
    check_eq({tag, "_err"}, t_err, e);
    check_eq({tag, "_ce"}, t_ce, halves * (2 + Acc));
    check_eq({tag, "_we"}, t_we, halves * Acc);
    check_eq({tag, "_oe"}, t_oe, 0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr);
    logic e = exp_err_of(addr);
    run_txn(1'b0, addr, 32'h0, 4'h0);
    check_eq({tag, "_lat"}, t_lat, e ? 1 : 2 * (1 + Acc) + 1);
    check_eq({tag, "_err"}, t_err, e);
    check_eq({tag, "_data"}, t_rdata,
             e ? 32'h0 : {ref_mem[hw_of(addr, 1)], ref_mem[hw_of(addr, 0)]});
    check_eq({tag, "_ce"}, t_ce, e ? 0 : 2 * (1 + Acc));
    check_eq({tag, "_oe"}, t_oe, e ? 0 : 2 * Acc);
    check_eq({tag, "_dqoe"}, t_dqoe, 0);
  endtask

  initial begin
    int mism;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 16'(i * 37 + 5);
      ref_mem[i] = 16'(i * 37 + 5);
    end

    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_ctrl",
             {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe, bus_ack, bus_err},
             8'b1111_1000);
    check_eq("rst_addr", sram_addr, 0);
    check_eq("rst_dq", sram_dq_out, 0);
    check_eq("rst_rdata", bus_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_write("wr_full", 32'h100, 32'hDEADBEEF, 4'hF);
    check_eq("hw80", ref_mem[32'h80], 16'hBEEF);
    check_eq("hw81", ref_mem[32'h81], 16'hDEAD);
    do_read("rd_full", 32'h100);
    do_write("wr_byte0", 32'h204, 32'h000000AA, 4'b0001);
    do_read("rd_byte0", 32'h204);
    do_write("wr_hi_only", 32'h208, 32'h12345678, 4'b1000);
    do_read("rd_hi_only", 32'h208);
    do_write("wr_none", 32'h20C, 32'hFFFFFFFF, 4'b0000);
    do_read("rd_alias", 32'h0008_0000);

    // Asynchronous reset in the middle of a write access.
    @(negedge clk);
    bus_req = 1'b1; bus_write = 1'b1; bus_addr = 32'h300; bus_wdata = 32'hCAFEF00D;
    bus_byte_en = 4'hF;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    check_eq("mid_we_low", sram_we_n, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ctrl",
             {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe, bus_ack},
             7'b1111_100);
    bus_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_write("post_rst_wr", 32'h300, 32'h0BADF00D, 4'hF);
    do_read("post_rst_rd", 32'h300);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = 32'h40 + ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 1) == 1) do_write("rnd_wr", a, $urandom, 4'($urandom));
      else                           do_read("rnd_rd", a);
    end

    mism = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
    check_eq("mem_final", mism, 0);
    check_eq("oe_overlap", overlap_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
